// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the 2x2 output-stationary systolic array.
//   DATA_W : operand width (unsigned)
//   ACC_W  : accumulator / result width (unsigned, wraps modulo 2^ACC_W)
//   data_t : operand type
//   acc_t  : accumulator type
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ACC_W-1:0]  acc_t;

endpackage : systolic_pkg

// File: rtl/systolic_pe.sv
// ----------------------------------------------------------------------------
// systolic_pe
// One processing element: multiplies its row and column operands and adds the
// full-width product into a private accumulator every clock edge.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low clear of the accumulator
//   a    : row operand
//   b    : column operand
//   acc  : registered accumulator value
// ----------------------------------------------------------------------------
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ACC_W_P  = ACC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W_P-1:0] a,
    input  logic [DATA_W_P-1:0] b,
    output logic [ACC_W_P-1:0]  acc
);

    logic [2*DATA_W_P-1:0] prod_s;
    logic [ACC_W_P-1:0]    acc_d;
    logic [ACC_W_P-1:0]    acc_q;

    // Product and next accumulator value; the sum is truncated so it wraps.
    always_comb begin
        prod_s = a * b;
        acc_d  = acc_q + ACC_W_P'(prod_s);
    end

    // Accumulator register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= {ACC_W_P{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule : systolic_pe

// File: rtl/systolic_array_2x2.sv
// ----------------------------------------------------------------------------
// systolic_array_2x2
// 2x2 output-stationary matrix-multiply core. Each edge adds the outer product
// of one A column (a1,a2) and one B row (b1,b2) into four accumulators, so
// after K edges c11..c22 hold C = A*B. Operands go straight to the PEs (no
// skew, no inter-PE propagation). Only reset clears the accumulators.
// Ports:
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset, clears all outputs
//   a1, a2         : A[0][k], A[1][k]
//   b1, b2         : B[k][0], B[k][1]
//   c11,c12,c21,c22: registered accumulators C[i][j]
// ----------------------------------------------------------------------------
module systolic_array_2x2
    import systolic_pkg::*;
#(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int ACC_W  = systolic_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    output logic [ACC_W-1:0]  c11,
    output logic [ACC_W-1:0]  c12,
    output logic [ACC_W-1:0]  c21,
    output logic [ACC_W-1:0]  c22
);

    logic [DATA_W-1:0] row_s [2];
    logic [DATA_W-1:0] col_s [2];
    logic [ACC_W-1:0]  acc_s [2][2];

    assign row_s[0] = a1;
    assign row_s[1] = a2;
    assign col_s[0] = b1;
    assign col_s[1] = b2;

    // Row operand i is shared along row i, column operand j along column j.
    for (genvar i = 0; i < 2; i++) begin : g_row
        for (genvar j = 0; j < 2; j++) begin : g_col
            systolic_pe #(
                .DATA_W_P (DATA_W),
                .ACC_W_P  (ACC_W)
            ) u_pe (
                .clk (clk),
                .rst (rst),
                .a   (row_s[i]),
                .b   (col_s[j]),
                .acc (acc_s[i][j])
            );
        end
    end

    assign c11 = acc_s[0][0];
    assign c12 = acc_s[0][1];
    assign c21 = acc_s[1][0];
    assign c22 = acc_s[1][1];

endmodule : systolic_array_2x2

// File: tb/tb_systolic_array_2x2.sv
module tb_systolic_array_2x2;

    logic        clk;
    logic        rst;
    logic [7:0]  a1, a2, b1, b2;
    logic [15:0] c11, c12, c21, c22;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] e11;
        logic [15:0] e12;
        logic [15:0] e21;
        logic [15:0] e22;
    } exp_t;

    typedef struct packed {
        logic        rst_before;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [7:0]  b1;
        logic [7:0]  b2;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [10];

    systolic_array_2x2 dut (
        .clk (clk),
        .rst (rst),
        .a1  (a1),
        .a2  (a2),
        .b1  (b1),
        .b2  (b2),
        .c11 (c11),
        .c12 (c12),
        .c21 (c21),
        .c22 (c22)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_all(input string name, input exp_t e);
        chk({name, ".c11"}, c11, e.e11);
        chk({name, ".c12"}, c12, e.e12);
        chk({name, ".c21"}, c21, e.e21);
        chk({name, ".c22"}, c22, e.e22);
    endtask

    // Drive one step at the falling edge, push the expectation, pop and
    // compare just after the rising edge.
    task automatic step(input string name, input logic [7:0] x1, input logic [7:0] x2,
                        input logic [7:0] y1, input logic [7:0] y2, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        a1 = x1; a2 = x2; b1 = y1; b2 = y2;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got_e = sb_q.pop_front();
            chk_all(name, got_e);
        end
    endtask

    // Assert reset between edges, check the asynchronous clear, then release
    // at a falling edge with zero operands.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        a1 = 8'd0; a2 = 8'd0; b1 = 8'd0; b2 = 8'd0;
        #2;
        rst = 1'b0;
        #1;
        chk_all(name, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        a1 = 8'd11; a2 = 8'd22; b1 = 8'd33; b2 = 8'd44;

        // Basic matmul, identity and wrap-around, expectations worked by hand.
        vecs[0] = '{1'b0, 8'd1,   8'd3,   8'd5,   8'd6,   '{16'd5,     16'd6,     16'd15,    16'd18}};
        vecs[1] = '{1'b0, 8'd2,   8'd4,   8'd7,   8'd8,   '{16'd19,    16'd22,    16'd43,    16'd50}};
        vecs[2] = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   '{16'd19,    16'd22,    16'd43,    16'd50}};
        vecs[3] = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   '{16'd19,    16'd22,    16'd43,    16'd50}};
        vecs[4] = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   '{16'd19,    16'd22,    16'd43,    16'd50}};
        vecs[5] = '{1'b1, 8'd1,   8'd0,   8'd9,   8'd8,   '{16'd9,     16'd8,     16'd0,     16'd0}};
        vecs[6] = '{1'b0, 8'd0,   8'd1,   8'd7,   8'd6,   '{16'd9,     16'd8,     16'd7,     16'd6}};
        vecs[7] = '{1'b1, 8'd255, 8'd255, 8'd255, 8'd255, '{16'd65025, 16'd65025, 16'd65025, 16'd65025}};
        vecs[8] = '{1'b0, 8'd255, 8'd255, 8'd255, 8'd255, '{16'd64514, 16'd64514, 16'd64514, 16'd64514}};
        vecs[9] = '{1'b0, 8'd255, 8'd255, 8'd255, 8'd255, '{16'd64003, 16'd64003, 16'd64003, 16'd64003}};

        // Held in reset with nonzero operands across several edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold", '0);
        end
        @(negedge clk);
        a1 = 8'd0; a2 = 8'd0; b1 = 8'd0; b2 = 8'd0;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_before) pulse_reset($sformatf("vec%0d_rst", i));
            step($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].b1, vecs[i].b2, vecs[i].exp);
        end

        // Idle hold after the wrapped result.
        for (int i = 0; i < 10; i++) begin
            step("idle_hold", 8'd0, 8'd0, 8'd0, 8'd0, '{16'd64003, 16'd64003, 16'd64003, 16'd64003});
        end

        // Mid-operation reset: one step in, then clear between edges while
        // operands of the second step are present.
        pulse_reset("pre_mid");
        step("mid_first", 8'd1, 8'd3, 8'd5, 8'd6, '{16'd5, 16'd6, 16'd15, 16'd18});
        @(negedge clk);
        a1 = 8'd2; a2 = 8'd4; b1 = 8'd7; b2 = 8'd8;
        rst = 1'b0;
        #1;
        chk_all("mid_async_clear", '0);
        @(posedge clk);
        #1;
        chk_all("mid_edge_in_reset", '0);
        @(negedge clk);
        a1 = 8'd0; a2 = 8'd0; b1 = 8'd0; b2 = 8'd0;
        rst = 1'b1;
        step("rerun1", 8'd1, 8'd3, 8'd5, 8'd6, '{16'd5, 16'd6, 16'd15, 16'd18});
        step("rerun2", 8'd2, 8'd4, 8'd7, 8'd8, '{16'd19, 16'd22, 16'd43, 16'd50});
        step("rerun_hold", 8'd0, 8'd0, 8'd0, 8'd0, '{16'd19, 16'd22, 16'd43, 16'd50});

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_systolic_array_2x2
